// File: rtl/alarm_cpu_debug_pkg.sv
// Shared FSM state type and jdo field positions for the OCI debug-RAM arbiter.
package alarm_cpu_debug_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_JRD,
    ST_JRD_WAIT,
    ST_JWR,
    ST_AV_RD,
    ST_AV_RD_WAIT,
    ST_AV_WR
  } arb_state_e;

  localparam int JDO_W         = 38;
  localparam int MON_W         = 32;
  localparam int JDO_RD_BIT    = 35;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/alarm_cpu_debug_rdlat_cnt.sv
// RAM read-latency countdown; 'last' marks the cycle in which read data is valid.
module alarm_cpu_debug_rdlat_cnt #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic last
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = 2'(RD_LAT - 1);
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == 2'd0);

endmodule

// File: rtl/alarm_cpu_debug_ocimem_arbiter.sv
// Shares the OCI debug RAM between the JTAG debug path and the CPU-side Avalon port.
// Optional Avalon write protection above PROTECT_BASE: define OCIMEM_AV_WPROT_EN.
module alarm_cpu_debug_ocimem_arbiter
  import alarm_cpu_debug_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter int                DATA_W       = 32,
  parameter int                RD_LAT       = 1,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hE0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [JDO_W-1:0]  jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic              av_waitrequest,
  output logic              av_readdatavalid,
  output logic [DATA_W-1:0] av_readdata,
`ifdef OCIMEM_AV_WPROT_EN
  output logic              av_wprot_viol,
`endif
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [MON_W-1:0]  MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic              jtag_rd_q, jtag_rd_d;
  logic              jtag_pend_q, jtag_pend_d;
  logic [MON_W-1:0]  jtag_wdata_q, jtag_wdata_d;
  logic [MON_W-1:0]  mon_dreg_q, mon_dreg_d;
  logic              monitor_ready_q, monitor_ready_d;
  logic              monitor_error_q, monitor_error_d;
  logic [DATA_W-1:0] av_readdata_q, av_readdata_d;
  logic              av_readdatavalid_q, av_readdatavalid_d;
`ifdef OCIMEM_AV_WPROT_EN
  logic              wprot_viol_q, wprot_viol_d;
`endif

  logic rd_last, cnt_start;
  logic req_rd, req_wr, req_new, overrun, jtag_req;
  logic av_in_prot, av_wr_allowed;
  logic unused_ok;

  assign cnt_start = (state_q == ST_JRD) || (state_q == ST_AV_RD);

  alarm_cpu_debug_rdlat_cnt #(.RD_LAT(RD_LAT)) u_rdlat_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (cnt_start),
    .last    (rd_last)
  );

  assign req_rd   = take_action_ocimem_a && jdo[JDO_RD_BIT];
  assign req_wr   = take_action_ocimem_b && !jtag_rd_q;
  assign req_new  = req_rd || req_wr;
  assign overrun  = req_new && jtag_pend_q;
  // A strobe arriving this cycle is arbitrated immediately, so an idle bus sees no extra cycle.
  assign jtag_req = jtag_pend_q || req_new;

  assign av_in_prot = (av_address >= PROTECT_BASE);
`ifdef OCIMEM_AV_WPROT_EN
  assign av_wr_allowed = !av_in_prot;
`else
  assign av_wr_allowed = 1'b1;
`endif
  assign unused_ok = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WDATA_LSB-1:0], av_in_prot};

  always_comb begin
    state_d            = state_q;
    jtag_addr_d        = jtag_addr_q;
    jtag_rd_d          = jtag_rd_q;
    jtag_pend_d        = jtag_pend_q;
    jtag_wdata_d       = jtag_wdata_q;
    mon_dreg_d         = mon_dreg_q;
    monitor_ready_d    = monitor_ready_q;
    monitor_error_d    = monitor_error_q;
    av_readdata_d      = av_readdata_q;
    av_readdatavalid_d = 1'b0;
`ifdef OCIMEM_AV_WPROT_EN
    wprot_viol_d       = wprot_viol_q;
`endif
    av_waitrequest     = 1'b1;
    ram_en             = 1'b0;
    ram_wr             = 1'b0;
    ram_addr           = jtag_addr_q;
    ram_wdata          = DATA_W'(jtag_wdata_q);

    // Strobes that land while a request is pending never disturb that request's fields.
    if (take_action_ocimem_a && !jtag_pend_q) begin
      jtag_addr_d = jdo[JDO_ADDR_LSB +: ADDR_W];
      jtag_rd_d   = jdo[JDO_RD_BIT];
    end
    if (req_wr && !jtag_pend_q) begin
      jtag_wdata_d = jdo[JDO_WDATA_LSB +: MON_W];
    end
    if (req_new && !jtag_pend_q) begin
      jtag_pend_d = 1'b1;
    end
    if (take_action_ocimem_a || take_action_ocimem_b) begin
      monitor_ready_d = 1'b0;
    end
    if (overrun) begin
      monitor_error_d = 1'b1;
    end else if (take_no_action_ocimem_a) begin
      monitor_error_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (jtag_req) begin
          state_d = jtag_rd_d ? ST_JRD : ST_JWR;
        end else if (av_read) begin
          state_d = ST_AV_RD;
        end else if (av_write) begin
          state_d = ST_AV_WR;
        end
      end
      ST_JRD: begin
        ram_en  = 1'b1;
        state_d = ST_JRD_WAIT;
      end
      ST_JRD_WAIT: begin
        if (rd_last) begin
          mon_dreg_d      = MON_W'(ram_rdata);
          monitor_ready_d = 1'b1;
          jtag_pend_d     = 1'b0;
          jtag_addr_d     = jtag_addr_q + ADDR_W'(1);
          state_d         = ST_IDLE;
        end
      end
      ST_JWR: begin
        ram_en          = 1'b1;
        ram_wr          = 1'b1;
        monitor_ready_d = 1'b1;
        jtag_pend_d     = 1'b0;
        jtag_addr_d     = jtag_addr_q + ADDR_W'(1);
`ifdef OCIMEM_AV_WPROT_EN
        wprot_viol_d    = 1'b0;
`endif
        state_d         = ST_IDLE;
      end
      ST_AV_RD: begin
        ram_en         = 1'b1;
        ram_addr       = av_address;
        av_waitrequest = 1'b0;
        state_d        = ST_AV_RD_WAIT;
      end
      ST_AV_RD_WAIT: begin
        if (rd_last) begin
          av_readdata_d      = ram_rdata;
          av_readdatavalid_d = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      ST_AV_WR: begin
        ram_en         = 1'b1;
        ram_wr         = av_wr_allowed;
        ram_addr       = av_address;
        ram_wdata      = av_writedata;
        av_waitrequest = 1'b0;
`ifdef OCIMEM_AV_WPROT_EN
        if (!av_wr_allowed) begin
          wprot_viol_d = 1'b1;
        end
`endif
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      jtag_addr_q        <= '0;
      jtag_rd_q          <= 1'b0;
      jtag_pend_q        <= 1'b0;
      jtag_wdata_q       <= '0;
      mon_dreg_q         <= '0;
      monitor_ready_q    <= 1'b0;
      monitor_error_q    <= 1'b0;
      av_readdata_q      <= '0;
      av_readdatavalid_q <= 1'b0;
`ifdef OCIMEM_AV_WPROT_EN
      wprot_viol_q       <= 1'b0;
`endif
    end else begin
      state_q            <= state_d;
      jtag_addr_q        <= jtag_addr_d;
      jtag_rd_q          <= jtag_rd_d;
      jtag_pend_q        <= jtag_pend_d;
      jtag_wdata_q       <= jtag_wdata_d;
      mon_dreg_q         <= mon_dreg_d;
      monitor_ready_q    <= monitor_ready_d;
      monitor_error_q    <= monitor_error_d;
      av_readdata_q      <= av_readdata_d;
      av_readdatavalid_q <= av_readdatavalid_d;
`ifdef OCIMEM_AV_WPROT_EN
      wprot_viol_q       <= wprot_viol_d;
`endif
    end
  end

  assign av_readdata      = av_readdata_q;
  assign av_readdatavalid = av_readdatavalid_q;
  assign MonDReg          = mon_dreg_q;
  assign monitor_ready    = monitor_ready_q;
  assign monitor_error    = monitor_error_q;
`ifdef OCIMEM_AV_WPROT_EN
  assign av_wprot_viol    = wprot_viol_q;
`endif

endmodule

// File: tb/tb_alarm_cpu_debug_ocimem_arbiter.sv
// Self-checking bench for the OCI debug-RAM arbiter: vector table, corner sequences, random traffic.
module tb_alarm_cpu_debug_ocimem_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 2;

  localparam int K_JWR = 0;
  localparam int K_JRD = 1;
  localparam int K_AVW = 2;
  localparam int K_AVR = 3;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic [37:0]       jdo = '0;
  logic [ADDR_W-1:0] av_address = '0;
  logic              av_read = 1'b0;
  logic              av_write = 1'b0;
  logic [DATA_W-1:0] av_writedata = '0;
  logic              av_waitrequest;
  logic              av_readdatavalid;
  logic [DATA_W-1:0] av_readdata;
  logic              ram_en;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;
`ifdef OCIMEM_AV_WPROT_EN
  logic              av_wprot_viol;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alarm_cpu_debug_ocimem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .PROTECT_BASE(8'hE0)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .jdo                     (jdo),
    .av_address              (av_address),
    .av_read                 (av_read),
    .av_write                (av_write),
    .av_writedata            (av_writedata),
    .av_waitrequest          (av_waitrequest),
    .av_readdatavalid        (av_readdatavalid),
    .av_readdata             (av_readdata),
`ifdef OCIMEM_AV_WPROT_EN
    .av_wprot_viol           (av_wprot_viol),
`endif
    .ram_en                  (ram_en),
    .ram_wr                  (ram_wr),
    .ram_addr                (ram_addr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  // RAM with RD_LAT-cycle read pipeline; idle slots carry a poison word
  logic [31:0] mem [256];
  logic [31:0] rd_pipe [RD_LAT];
  logic        mem_clear = 1'b1;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ram_en && ram_wr) begin
      mem[ram_addr] <= ram_wdata;
    end
    for (int k = RD_LAT - 1; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
    rd_pipe[0] <= (ram_en && !ram_wr) ? mem[ram_addr] : 32'hBAD0BAD0;
  end
  assign ram_rdata = rd_pipe[RD_LAT-1];

  // Reference contents of the RAM as seen by a correct arbiter
  logic [31:0] ref_mem [256];

  typedef struct {
    int          kind;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] expd;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expd);
    checks++;
    if (act !== expd) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, act, expd);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_a(input logic rd, input logic [7:0] addr);
    jdo = '0;
    jdo[35] = rd;
    jdo[33:26] = addr;
    take_action_ocimem_a = 1'b1;
    tick();
    take_action_ocimem_a = 1'b0;
  endtask

  task automatic strobe_b(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_action_ocimem_b = 1'b1;
    tick();
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic wait_ready(input string name, output int cyc);
    cyc = 0;
    while (!monitor_ready && cyc < 40) begin
      tick();
      cyc++;
    end
    if (!monitor_ready) checkOutput({name, " ready timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_rdv(input string name, output logic [31:0] d);
    int n = 0;
    while (!av_readdatavalid && n < 40) begin
      tick();
      n++;
    end
    if (!av_readdatavalid) checkOutput({name, " rdv timeout"}, 32'd0, 32'd1);
    d = av_readdata;
    tick();
    checkOutput({name, " rdv one cycle"}, {31'd0, av_readdatavalid}, 32'd0);
  endtask

  task automatic jtag_write(input logic [7:0] addr, input logic [31:0] d, input bit chk_lat);
    int cyc;
    strobe_a(1'b0, addr);
    strobe_b(d);
    wait_ready("jtag_write", cyc);
    if (chk_lat) checkOutput("jtag_write latency", 32'(cyc + 1), 32'd2);
  endtask

  task automatic jtag_read(input logic [7:0] addr, output logic [31:0] d, input bit chk_lat);
    int cyc;
    strobe_a(1'b1, addr);
    wait_ready("jtag_read", cyc);
    if (chk_lat) checkOutput("jtag_read latency", 32'(cyc + 1), 32'(2 + RD_LAT));
    d = MonDReg;
  endtask

  task automatic av_accept(input string name);
    int n = 0;
    while (av_waitrequest && n < 40) begin
      tick();
      n++;
    end
    if (av_waitrequest) checkOutput({name, " accept timeout"}, 32'd1, 32'd0);
  endtask

  task automatic av_write_op(input logic [7:0] addr, input logic [31:0] d);
    av_address = addr;
    av_writedata = d;
    av_write = 1'b1;
    av_accept("av_write");
    tick();
    av_write = 1'b0;
  endtask

  task automatic av_read_op(input logic [7:0] addr, output logic [31:0] d);
    av_address = addr;
    av_read = 1'b1;
    av_accept("av_read");
    tick();
    av_read = 1'b0;
    wait_rdv("av_read", d);
  endtask

  function automatic bit av_write_lands(input logic [7:0] addr);
`ifdef OCIMEM_AV_WPROT_EN
    return addr < 8'hE0;
`else
    return addr == addr;
`endif
  endfunction

  task automatic applyStimulus(input vec_t v);
    logic [31:0] d;
    case (v.kind)
      K_JWR: begin
        jtag_write(v.addr, v.data, 1'b1);
        ref_mem[v.addr] = v.data;
      end
      K_JRD: begin
        jtag_read(v.addr, d, 1'b1);
        checkOutput("table jtag_read data", d, v.expd);
      end
      K_AVW: begin
        av_write_op(v.addr, v.data);
        if (av_write_lands(v.addr)) ref_mem[v.addr] = v.data;
      end
      default: begin
        av_read_op(v.addr, d);
        checkOutput("table av_read data", d, v.expd);
      end
    endcase
  endtask

  initial begin
    logic [31:0] d;
    int ready_cyc, wr_cyc, pulses, cyc;

    for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;

    vecs[0] = '{K_JWR, 8'h10, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{K_JRD, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{K_AVW, 8'h05, 32'h12345678, 32'h0};
    vecs[3] = '{K_AVR, 8'h05, 32'h0,        32'h12345678};
    vecs[4] = '{K_JRD, 8'h05, 32'h0,        32'h12345678};
    vecs[5] = '{K_AVR, 8'h10, 32'h0,        32'hDEADBEEF};
    vecs[6] = '{K_AVW, 8'h80, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{K_JRD, 8'h80, 32'h0,        32'hCAFEF00D};
    vecs[8] = '{K_JWR, 8'h00, 32'h00000001, 32'h0};
    vecs[9] = '{K_AVR, 8'h00, 32'h0,        32'h00000001};

    tick();
    mem_clear = 1'b0;
    tick();
    checkOutput("reset av_waitrequest", {31'd0, av_waitrequest}, 32'd1);
    checkOutput("reset av_readdatavalid", {31'd0, av_readdatavalid}, 32'd0);
    checkOutput("reset ram_en", {31'd0, ram_en}, 32'd0);
    checkOutput("reset MonDReg", MonDReg, 32'd0);
    checkOutput("reset monitor_ready", {31'd0, monitor_ready}, 32'd0);
    checkOutput("reset monitor_error", {31'd0, monitor_error}, 32'd0);
`ifdef OCIMEM_AV_WPROT_EN
    checkOutput("reset av_wprot_viol", {31'd0, av_wprot_viol}, 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Auto-increment across the top of the address space
    strobe_a(1'b0, 8'hFF);
    strobe_b(32'hA1A1A1A1);
    wait_ready("wrap first", cyc);
    strobe_b(32'hA2A2A2A2);
    wait_ready("wrap second", cyc);
    ref_mem[8'hFF] = 32'hA1A1A1A1;
    ref_mem[8'h00] = 32'hA2A2A2A2;
    av_read_op(8'hFF, d);
    checkOutput("wrap word 0xFF", d, 32'hA1A1A1A1);
    av_read_op(8'h00, d);
    checkOutput("wrap word 0x00", d, 32'hA2A2A2A2);

    // Avalon read and JTAG read requested in the same idle cycle
    av_write_op(8'h20, 32'h20202020);
    ref_mem[8'h20] = 32'h20202020;
    av_address = 8'h20;
    av_read = 1'b1;
    strobe_a(1'b1, 8'h10);
    ready_cyc = -1;
    wr_cyc = 99;
    for (int n = 0; n < 40; n++) begin
      if (monitor_ready && ready_cyc < 0) ready_cyc = n;
      if (!av_waitrequest) begin
        wr_cyc = n;
        break;
      end
      tick();
    end
    checkOutput("jtag served before avalon", {31'd0, (ready_cyc >= 0 && ready_cyc < wr_cyc)}, 32'd1);
    checkOutput("simultaneous MonDReg", MonDReg, ref_mem[8'h10]);
    tick();
    av_read = 1'b0;
    wait_rdv("simultaneous", d);
    checkOutput("simultaneous av_readdata", d, 32'h20202020);

    // JTAG write overrun while stalled behind an Avalon read
    strobe_a(1'b0, 8'h40);
    av_address = 8'h30;
    av_read = 1'b1;
    av_accept("overrun av_read");
    jdo = '0;
    jdo[34:3] = 32'h0D1D1D1D;
    take_action_ocimem_b = 1'b1;
    tick();
    av_read = 1'b0;
    jdo[34:3] = 32'h0D2D2D2D;
    tick();
    take_action_ocimem_b = 1'b0;
    checkOutput("overrun monitor_error set", {31'd0, monitor_error}, 32'd1);
    wait_rdv("overrun", d);
    checkOutput("overrun av_readdata", d, ref_mem[8'h30]);
    wait_ready("overrun write", cyc);
    ref_mem[8'h40] = 32'h0D1D1D1D;
    checkOutput("overrun error sticky", {31'd0, monitor_error}, 32'd1);
    take_no_action_ocimem_a = 1'b1;
    tick();
    take_no_action_ocimem_a = 1'b0;
    checkOutput("overrun error cleared", {31'd0, monitor_error}, 32'd0);
    jtag_read(8'h40, d, 1'b1);
    checkOutput("overrun first data kept", d, 32'h0D1D1D1D);
    av_read_op(8'h41, d);
    checkOutput("overrun second data dropped", d, ref_mem[8'h41]);

    // Reset in the middle of an Avalon read
    av_write_op(8'h50, 32'h55AA55AA);
    ref_mem[8'h50] = 32'h55AA55AA;
    av_address = 8'h50;
    av_read = 1'b1;
    av_accept("reset av_read");
    tick();
    av_read = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset av_waitrequest", {31'd0, av_waitrequest}, 32'd1);
    checkOutput("midreset av_readdatavalid", {31'd0, av_readdatavalid}, 32'd0);
    checkOutput("midreset MonDReg", MonDReg, 32'd0);
    checkOutput("midreset monitor_ready", {31'd0, monitor_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      if (av_readdatavalid) pulses++;
      tick();
    end
    checkOutput("midreset no rdv pulse", 32'(pulses), 32'd0);
    checkOutput("midreset idle waitrequest", {31'd0, av_waitrequest}, 32'd1);

`ifdef OCIMEM_AV_WPROT_EN
    jtag_write(8'hE5, 32'h11111111, 1'b1);
    ref_mem[8'hE5] = 32'h11111111;
    av_write_op(8'hE5, 32'h22222222);
    checkOutput("wprot viol set", {31'd0, av_wprot_viol}, 32'd1);
    jtag_read(8'hE5, d, 1'b1);
    checkOutput("wprot word untouched", d, 32'h11111111);
    av_write_op(8'h05, 32'h33333333);
    ref_mem[8'h05] = 32'h33333333;
    av_read_op(8'h05, d);
    checkOutput("wprot low word written", d, 32'h33333333);
    checkOutput("wprot viol sticky", {31'd0, av_wprot_viol}, 32'd1);
    jtag_write(8'h06, 32'h44444444, 1'b1);
    ref_mem[8'h06] = 32'h44444444;
    checkOutput("wprot viol cleared", {31'd0, av_wprot_viol}, 32'd0);
`endif

    // Random transactions against the reference memory
    for (int n = 0; n < 60; n++) begin
      vec_t v;
      v.kind = int'($urandom_range(0, 3));
      v.addr = 8'($urandom_range(0, 255));
      v.data = $urandom;
      v.expd = ref_mem[v.addr];
      applyStimulus(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
